// File: rtl/uart_rx.sv
// UART receiver: start, DATA bits LSB first, XOR parity, one stop bit.
// Mid-bit sampling from an internal counter; result on a 1-cycle valid strobe.
module uart_rx #(
  parameter int DATA         = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  output logic            rx_parity_err,
  output logic            rx_frame_err,
  output logic            rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA) + 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [1:0]       r_sync;
  logic             r_rxs_prev;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [DATA-1:0]  r_shift;
  logic             r_perr;
  logic             w_rxs;
  logic             w_bit_end;

  assign w_rxs     = r_sync[1];
  assign w_bit_end = (r_cnt == BIT_LAST);

  // Synchronizer and edge history reset to the idle (high) line level so
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_rxs_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so r_sync[1] takes last cycle's r_sync[0], giving two real flops.
      r_sync     <= {r_sync[0], rx_in};
      r_rxs_prev <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_perr        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rxs_prev && !w_rxs) begin
            r_state <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            // A line back high at mid start bit was only a glitch.
            if (w_rxs) begin
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[DATA-1:1]};
            if (r_bit_cnt == DATA_LAST) r_state <= S_PARITY;
            else                        r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_perr  <= w_rxs ^ (^r_shift);
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt         <= '0;
            rx_data       <= r_shift;
            rx_parity_err <= r_perr;
            rx_frame_err  <= ~w_rxs;
            rx_valid      <= 1'b1;
            rx_busy       <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
